// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-set sequencer choosing which strobe source advances the clock counter
// Idle passes the 1 Hz strobe to seconds; a held button gives one step, slow repeat, then fast repeat.
module clock_set_ctrl #(
  parameter int FAST_AFTER = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_1hz_stb,
  input  logic       i_slow_set_stb,
  input  logic       i_fast_set_stb,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  output logic       o_sec_inc_stb,
  output logic       o_min_inc_stb,
  output logic       o_hr_inc_stb,
  output logic       o_sec_clr_stb,
  output logic       o_set_active,
  output logic [1:0] o_state
);

  localparam int CW = $clog2(FAST_AFTER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SLOW = 2'd1;
  localparam logic [1:0] S_FAST = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(FAST_AFTER);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_field_hr;
  logic          w_field_hr_nxt;
  logic          r_hist_hr;
  logic          r_hist_min;
  logic          r_sec_inc;
  logic          r_min_inc;
  logic          r_hr_inc;
  logic          w_sec_inc;
  logic          w_min_inc;
  logic          w_hr_inc;
  logic          w_step;
  logic          w_press_hr;
  logic          w_press_min;
  logic          w_held;

  // History resets high so a button held through reset is not seen as a press.
  assign w_press_hr  = i_set_hours   & ~r_hist_hr;
  assign w_press_min = i_set_minutes & ~r_hist_min;
  assign w_held      = r_field_hr ? i_set_hours : i_set_minutes;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_field_hr_nxt = r_field_hr;
    w_sec_inc      = 1'b0;
    w_step         = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press_hr || w_press_min) begin
            w_field_hr_nxt = w_press_hr;
            w_step         = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_SLOW;
          end else begin
            w_sec_inc = i_1hz_stb;
          end
        end
        S_SLOW: begin
          if (!w_held) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (i_slow_set_stb) begin
            w_step    = 1'b1;
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST - CNT_ONE) begin
              w_state_nxt = S_FAST;
            end
          end
        end
        S_FAST: begin
          if (!w_held) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (i_fast_set_stb) begin
            w_step = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_min_inc = w_step & ~w_field_hr_nxt;
  assign w_hr_inc  = w_step &  w_field_hr_nxt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_field_hr <= 1'b0;
      r_hist_hr  <= 1'b1;
      r_hist_min <= 1'b1;
      r_sec_inc  <= 1'b0;
      r_min_inc  <= 1'b0;
      r_hr_inc   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_field_hr <= w_field_hr_nxt;
      r_hist_hr  <= i_set_hours;
      r_hist_min <= i_set_minutes;
      r_sec_inc  <= w_sec_inc;
      r_min_inc  <= w_min_inc;
      r_hr_inc   <= w_hr_inc;
    end
  end

  assign o_sec_inc_stb = r_sec_inc;
  assign o_min_inc_stb = r_min_inc;
  assign o_hr_inc_stb  = r_hr_inc;
  assign o_sec_clr_stb = r_min_inc;
  assign o_set_active  = (r_state != S_IDLE);
  assign o_state       = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - table-driven scoreboard bench for clock_set_ctrl
module tb_clock_set_ctrl;

  localparam int FA = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       hz = 1'b0;
  logic       slow = 1'b0;
  logic       fast = 1'b0;
  logic       hr = 1'b0;
  logic       mn = 1'b0;
  logic       o_sec, o_min, o_hr, o_clr, o_act;
  logic [1:0] o_st;

  typedef struct {
    logic       en, hz, slow, fast, hr, mn;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  clock_set_ctrl #(.FAST_AFTER(FA)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_en           (en),
    .i_1hz_stb      (hz),
    .i_slow_set_stb (slow),
    .i_fast_set_stb (fast),
    .i_set_hours    (hr),
    .i_set_minutes  (mn),
    .o_sec_inc_stb  (o_sec),
    .o_min_inc_stb  (o_min),
    .o_hr_inc_stb   (o_hr),
    .o_sec_clr_stb  (o_clr),
    .o_set_active   (o_act),
    .o_state        (o_st)
  );

  always #40 clk = ~clk;

  // Expected output word: {sec, min, hr, clr, active, state}
  function automatic logic [6:0] e(input logic s, input logic m, input logic h, input logic c,
                                   input logic [1:0] st);
    return {s, m, h, c, (st != 2'd0), st};
  endfunction

  function automatic vec_t v(input logic en_i, input logic hz_i, input logic sl_i, input logic fa_i,
                             input logic hr_i, input logic mn_i, input logic [6:0] x);
    vec_t r;
    r.en = en_i; r.hz = hz_i; r.slow = sl_i; r.fast = fa_i; r.hr = hr_i; r.mn = mn_i; r.exp = x;
    return r;
  endfunction

  function automatic logic [6:0] actual();
    return {o_sec, o_min, o_hr, o_clr, o_act, o_st};
  endfunction

  task automatic check(input string tag, input logic [6:0] want);
    logic [6:0] got;
    got = actual();
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %b want %b (sec,min,hr,clr,act,state)", tag, got, want);
    end
  endtask

  task automatic pop_check();
    sb_t s;
    if (sb.size() > 0) begin
      s = sb.pop_front();
      check(s.tag, s.exp);
    end
  endtask

  task automatic drive(input vec_t x, input string tag);
    sb_t s;
    @(negedge clk);
    pop_check();
    en = x.en; hz = x.hz; slow = x.slow; fast = x.fast; hr = x.hr; mn = x.mn;
    s.tag = tag;
    s.exp = x.exp;
    sb.push_back(s);
  endtask

  task automatic drain();
    @(negedge clk);
    pop_check();
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], $sformatf("%s[%0d]", name, i));
    end
    drain();
    vecs.delete();
  endtask

  initial begin
    // Reset state
    #100;
    check("reset_hold", e(0, 0, 0, 0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle seconds pass-through
    vecs.push_back(v(1, 1, 0, 0, 0, 0, e(1, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, e(1, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, e(1, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    run_table("idle_sec");

    // 2: minutes held through slow then fast repeat
    vecs.push_back(v(1, 0, 0, 0, 0, 1, e(0, 1, 0, 1, 1)));
    vecs.push_back(v(1, 0, 0, 1, 0, 1, e(0, 0, 0, 0, 1)));
    vecs.push_back(v(1, 0, 1, 0, 0, 1, e(0, 1, 0, 1, 1)));
    vecs.push_back(v(1, 0, 1, 0, 0, 1, e(0, 1, 0, 1, 1)));
    vecs.push_back(v(1, 1, 0, 0, 0, 1, e(0, 0, 0, 0, 1)));
    vecs.push_back(v(1, 0, 1, 0, 0, 1, e(0, 1, 0, 1, 1)));
    vecs.push_back(v(1, 0, 1, 0, 0, 1, e(0, 1, 0, 1, 2)));
    vecs.push_back(v(1, 0, 1, 0, 0, 1, e(0, 0, 0, 0, 2)));
    vecs.push_back(v(1, 0, 0, 1, 0, 1, e(0, 1, 0, 1, 2)));
    vecs.push_back(v(1, 0, 1, 0, 0, 1, e(0, 0, 0, 0, 2)));
    vecs.push_back(v(1, 0, 0, 1, 0, 1, e(0, 1, 0, 1, 2)));
    vecs.push_back(v(1, 1, 0, 1, 0, 1, e(0, 1, 0, 1, 2)));
    vecs.push_back(v(1, 0, 0, 1, 0, 1, e(0, 1, 0, 1, 2)));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    run_table("min_repeat");

    // 3: simultaneous press, hours wins; other button ignored and needs re-press
    vecs.push_back(v(1, 0, 0, 0, 1, 1, e(0, 0, 1, 0, 1)));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, e(0, 0, 0, 0, 1)));
    vecs.push_back(v(1, 0, 1, 0, 1, 0, e(0, 0, 1, 0, 1)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, e(0, 0, 1, 0, 1)));
    vecs.push_back(v(1, 0, 0, 0, 1, 1, e(0, 0, 0, 0, 1)));
    vecs.push_back(v(1, 0, 1, 0, 0, 1, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    run_table("both_press");

    // 4: release coincident with slow strobe, then 1 Hz passes again
    vecs.push_back(v(1, 0, 0, 0, 0, 1, e(0, 1, 0, 1, 1)));
    vecs.push_back(v(1, 0, 1, 0, 0, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, e(1, 0, 0, 0, 0)));
    run_table("rel_slow");

    // 5: async reset while in FAST with button held; held button needs re-press
    drive(v(1, 0, 0, 0, 0, 1, e(0, 1, 0, 1, 1)), "rst_press");
    for (int i = 0; i < FA; i++) begin
      drive(v(1, 0, 1, 0, 0, 1, e(0, 1, 0, 1, (i == FA - 1) ? 2'd2 : 2'd1)),
            $sformatf("rst_slow%0d", i));
    end
    drain();
    #10 rst_n = 1'b0;
    #1 check("async_rst", e(0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_held", e(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    vecs.push_back(v(1, 0, 0, 1, 0, 1, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 1, 0, 0, 1, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 1, e(0, 1, 0, 1, 1)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    run_table("post_rst");

    // 6: disable during FAST with button held
    drive(v(1, 0, 0, 0, 1, 0, e(0, 0, 1, 0, 1)), "en_press");
    for (int i = 0; i < FA; i++) begin
      drive(v(1, 0, 1, 0, 1, 0, e(0, 0, 1, 0, (i == FA - 1) ? 2'd2 : 2'd1)),
            $sformatf("en_slow%0d", i));
    end
    vecs.push_back(v(0, 1, 0, 1, 1, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 1, 1, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 1, 0, 1, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, e(0, 0, 1, 0, 1)));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    run_table("en_drop");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
